// File: rtl/dbus_access_ctrl_pkg.sv
// rtl/dbus_access_ctrl_pkg.sv - shared encodings and helpers for the data-bus access controller
package dbus_access_ctrl_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic {
    UNSIGNED = 1'b0,
    SIGNED   = 1'b1
  } sig_t;

  typedef logic [1:0] dbus_state_t;
  localparam dbus_state_t IDLE  = 2'd0;
  localparam dbus_state_t ADDR  = 2'd1;
  localparam dbus_state_t DATA  = 2'd2;
  localparam dbus_state_t DRAIN = 2'd3;

  function automatic logic is_aligned(input logic [1:0] off, input msize_t sz);
    case (sz)
      MSIZE1:  return 1'b1;
      MSIZE2:  return ~off[0];
      MSIZE4:  return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] calc_strobe(input logic [1:0] off, input msize_t sz);
    case (sz)
      MSIZE1:  return 4'b0001 << off;
      MSIZE2:  return 4'b0011 << off;
      MSIZE4:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Store data is replicated so every byte lane carries the value the strobe selects.
  function automatic logic [31:0] replicate_wdata(input logic [31:0] w, input msize_t sz);
    case (sz)
      MSIZE1:  return {4{w[7:0]}};
      MSIZE2:  return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/dbus_access_ctrl_if.sv
// rtl/dbus_access_ctrl_if.sv - pipeline request and data-bus signal bundle
interface dbus_access_ctrl_if;
  import dbus_access_ctrl_pkg::*;

  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  msize_t      req_msize;
  sig_t        req_sig;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        addr_err;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  msize_t      dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_msize, req_sig, req_wdata, flush,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    output stall, resp_valid, resp_rdata, addr_err,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );

  modport master (
    output req_valid, req_write, req_addr, req_msize, req_sig, req_wdata, flush,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    input  stall, resp_valid, resp_rdata, addr_err,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );

endinterface

// File: rtl/dbus_access_ctrl_dresp_extract.sv
// rtl/dbus_access_ctrl_dresp_extract.sv - lane select and sign/zero extension of a raw read word
module dresp_extract
  import dbus_access_ctrl_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  msize_t      msize_i,
  input  sig_t        sig_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;

  always_comb begin
    byte_v = raw_i[{off_i, 3'b000} +: 8];
    half_v = off_i[1] ? raw_i[31:16] : raw_i[15:0];
    sext   = (sig_i == SIGNED);
    data_o = '0;
    case (msize_i)
      MSIZE1: data_o = {{24{sext & byte_v[7]}}, byte_v};
      MSIZE2: if (!off_i[0]) data_o = {{16{sext & half_v[15]}}, half_v};
      MSIZE4: if (off_i == 2'b00) data_o = raw_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/dbus_access_ctrl.sv
// rtl/dbus_access_ctrl.sv - memory-stage load/store controller driving a split address/data bus
module dbus_access_ctrl
  import dbus_access_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  dbus_access_ctrl_if.slave  bus
);

  dbus_state_t state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  msize_t      size_q;
  sig_t        sig_q;
  logic        write_q;
  logic [31:0] rdata_q, rdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        addr_err_q, addr_err_d;
  logic        req_aligned, accept, complete;
  logic [31:0] ext_data;

  dresp_extract u_extract (
    .raw_i   (bus.dresp_data),
    .off_i   (addr_q[1:0]),
    .msize_i (size_q),
    .sig_i   (sig_q),
    .data_o  (ext_data)
  );

  always_comb begin
    req_aligned = is_aligned(bus.req_addr[1:0], bus.req_msize);
    accept      = (state_q == IDLE) & bus.req_valid & req_aligned & ~bus.flush;
    addr_err_d  = (state_q == IDLE) & bus.req_valid & ~req_aligned;
    state_d     = state_q;
    complete    = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = ADDR;
      // A flush that races the bus acceptance still owes a data_ok, hence DRAIN.
      ADDR: begin
        if (bus.dresp_addr_ok) begin
          if (bus.dresp_data_ok) begin
            state_d  = IDLE;
            complete = ~bus.flush;
          end else begin
            state_d = bus.flush ? DRAIN : DATA;
          end
        end else if (bus.flush) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (bus.dresp_data_ok) begin
          state_d  = IDLE;
          complete = ~bus.flush;
        end else if (bus.flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: if (bus.dresp_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    resp_valid_d = complete;
    rdata_d      = complete ? (write_q ? 32'd0 : ext_data) : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= MSIZE1;
      sig_q        <= UNSIGNED;
      write_q      <= 1'b0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      addr_err_q   <= addr_err_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_msize;
        sig_q   <= bus.req_sig;
        write_q <= bus.req_write;
      end
    end
  end

  assign bus.stall       = (state_q != IDLE) | accept;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.dreq_valid  = (state_q == ADDR);
  assign bus.dreq_addr   = addr_q;
  assign bus.dreq_size   = size_q;
  assign bus.dreq_strobe = write_q ? calc_strobe(addr_q[1:0], size_q) : 4'b0000;
  assign bus.dreq_data   = replicate_wdata(wdata_q, size_q);

endmodule
